// File: rtl/ifu_fetch_unit_if.sv
// rtl/ifu_fetch_unit_if.sv - fetch unit bundle: PC request, AR/R read bus, instruction response
// master is the fetch unit side; slave is the environment (PC stage, memory, IDU).
interface ifu_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic            flush;

  logic            mem_arvalid;
  logic            mem_arready;
  logic [XLEN-1:0] mem_araddr;
  logic            mem_rvalid;
  logic            mem_rready;
  logic [XLEN-1:0] mem_rdata;
  logic [1:0]      mem_rresp;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;
  logic [1:0]      out_exc;

  modport master (
    input  in_valid, in_pc, flush,
    input  mem_arready, mem_rvalid, mem_rdata, mem_rresp,
    input  out_ready,
    output in_ready,
    output mem_arvalid, mem_araddr, mem_rready,
    output out_valid, out_pc, out_inst, out_exc
  );

  modport slave (
    output in_valid, in_pc, flush,
    output mem_arready, mem_rvalid, mem_rdata, mem_rresp,
    output out_ready,
    input  in_ready,
    input  mem_arvalid, mem_araddr, mem_rready,
    input  out_valid, out_pc, out_inst, out_exc
  );
endinterface

// File: rtl/ifu_fetch_unit.sv
// rtl/ifu_fetch_unit.sv - non-pipelined instruction fetch unit, one outstanding read
// Handshaked PC in, single AR/R read, {pc, inst, exc} out; flush drops in-flight work.
module ifu_fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     ALIGN_BITS = 2,
  parameter logic [XLEN-1:0] NOP_INST   = XLEN'(32'h0000_0013)
) (
  input  logic               clk,
  input  logic               rst,
  ifu_fetch_unit_if.master   bus
);

  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_ALIGN = 2'b01;
  localparam logic [1:0] EXC_FAULT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [1:0]      exc_q, exc_d;
  logic            misaligned;

  assign misaligned = (bus.in_pc & ALIGN_MASK) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      exc_q   <= EXC_NONE;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    exc_d   = exc_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          pc_d = bus.in_pc;
          if (misaligned) begin
            inst_d  = NOP_INST;
            exc_d   = EXC_ALIGN;
            state_d = S_DONE;
          end else begin
            state_d = S_AR;
          end
        end
      end

      // The address handshake is never withdrawn; a redirect only marks the response stale.
      S_AR: begin
        if (bus.flush) begin
          drop_d = 1'b1;
        end
        if (bus.mem_arready) begin
          state_d = S_R;
        end
      end

      S_R: begin
        if (bus.mem_rvalid) begin
          if (drop_q || bus.flush) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            if (bus.mem_rresp == 2'b00) begin
              inst_d = bus.mem_rdata;
              exc_d  = EXC_NONE;
            end else begin
              inst_d = NOP_INST;
              exc_d  = EXC_FAULT;
            end
            state_d = S_DONE;
          end
        end else if (bus.flush) begin
          drop_d = 1'b1;
        end
      end

      S_DONE: begin
        if (bus.out_ready || bus.flush) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.mem_arvalid = (state_q == S_AR);
  assign bus.mem_rready  = (state_q == S_R);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.mem_araddr  = pc_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_inst    = inst_q;
  assign bus.out_exc     = exc_q;

endmodule
